// File: rtl/dpram_pkg.sv
// Shared constants for the single-clock true dual-port RAM and the
// streaming FIFO controller that owns it.
//   DPRAM_DW    : RAM word width
//   DPRAM_AW    : RAM address width
//   DPRAM_DEPTH : RAM depth (2**DPRAM_AW)
package dpram_pkg;

    localparam int DPRAM_DW    = 8;
    localparam int DPRAM_AW    = 6;
    localparam int DPRAM_DEPTH = 1 << DPRAM_AW;

endpackage : dpram_pkg

// File: rtl/true_dpram_sclk.sv
// Single-clock true dual-port RAM, registered read on port B.
// Ports:
//   clk    : the only clock
//   addr_a : port A address     data_a : port A write data   we_a : port A write enable
//   addr_b : port B address     data_b : port B write data   we_b : port B write enable
//   q_b    : port B read data, one cycle after addr_b is presented (old data on collision)
// The FIFO controller only writes through A and only reads through B, so
// port A carries no read data path.
module true_dpram_sclk
    import dpram_pkg::*;
#(
    parameter int DW = DPRAM_DW,
    parameter int AW = DPRAM_AW
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] data_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] data_b,
    input  logic          we_b,
    output logic [DW-1:0] q_b
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_a;
        if (we_b) mem[addr_b] <= data_b;
        q_b <= mem[addr_b];
    end

endmodule : true_dpram_sclk

// File: rtl/dpram_stream_fifo.sv
// Valid/ready streaming FIFO built around true_dpram_sclk.
// Port A of the RAM takes producer writes, port B feeds a 2-entry
// first-word-fall-through output buffer (OB) that hides the RAM read latency.
// Handshake: a word moves on an input or output side exactly at a rising
// clk edge where its valid and ready are both 1; valid never depends on ready
// and in_ready never depends on the same-cycle pop.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   clr               : synchronous flush, overrides all traffic
//   in_data/in_valid  : producer word and its valid
//   in_ready          : FIFO accepts a word this cycle
//   out_data/out_valid: head word (OB slot 0) and its valid
//   out_ready         : consumer takes the head word
//   level             : words held in RAM + read in flight + OB
module dpram_stream_fifo
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = DPRAM_DW,
    parameter int ADDR_WIDTH = DPRAM_AW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   level
);

    // ram_count value meaning "all DEPTH RAM locations are occupied"
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic                  ready_en_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic [1:0]            ob_count_q, ob_count_d;
    logic [DATA_WIDTH-1:0] ob0_q, ob0_d;
    logic [DATA_WIDTH-1:0] ob1_q, ob1_d;

    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occ;
    logic [1:0]            ob_after_pop;
    logic [DATA_WIDTH-1:0] q_b;

    assign in_ready  = ready_en_q & (ram_count_q != FULL_CNT);
    assign out_valid = (ob_count_q != 2'd0);
    assign out_data  = ob0_q;
    assign level     = ram_count_q
                     + (ADDR_WIDTH+1)'(rd_inflight_q)
                     + (ADDR_WIDTH+1)'(ob_count_q);

    assign push = in_valid & in_ready & ~clr;
    assign pop  = out_valid & out_ready;

    // OB slots that will be spoken for once this cycle's pop and any
    // in-flight read land; a new read is only issued if it has a slot.
    assign occ   = 3'(ob_count_q) + 3'(rd_inflight_q) - 3'(pop);
    assign issue = (ram_count_q != '0) & (occ < 3'd2) & ~clr;

    assign ob_after_pop = ob_count_q - 2'(pop);

    always_comb begin
        wr_ptr_d      = wr_ptr_q + ADDR_WIDTH'(push);
        rd_ptr_d      = rd_ptr_q + ADDR_WIDTH'(issue);
        rd_inflight_d = issue;

        ram_count_d = ram_count_q;
        if (push && !issue)      ram_count_d = ram_count_q + (ADDR_WIDTH+1)'(1'b1);
        else if (issue && !push) ram_count_d = ram_count_q - (ADDR_WIDTH+1)'(1'b1);

        // Pop shifts slot 1 down; a landing read fills the first free slot
        // left after that shift.
        ob0_d = pop ? ob1_q : ob0_q;
        ob1_d = ob1_q;
        if (rd_inflight_q) begin
            if (ob_after_pop == 2'd0) ob0_d = q_b;
            else                      ob1_d = q_b;
        end
        ob_count_d = ob_after_pop + 2'(rd_inflight_q);

        // Flush drops any same-cycle push and any read data still in flight.
        if (clr) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            ram_count_d   = '0;
            rd_inflight_d = 1'b0;
            ob_count_d    = 2'd0;
            ob0_d         = '0;
            ob1_d         = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ram_count_q   <= '0;
            rd_inflight_q <= 1'b0;
            ob_count_q    <= 2'd0;
            ob0_q         <= '0;
            ob1_q         <= '0;
        end else begin
            ready_en_q    <= 1'b1;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ram_count_q   <= ram_count_d;
            rd_inflight_q <= rd_inflight_d;
            ob_count_q    <= ob_count_d;
            ob0_q         <= ob0_d;
            ob1_q         <= ob1_d;
        end
    end

    true_dpram_sclk #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .addr_a (wr_ptr_q),
        .data_a (in_data),
        .we_a   (push),
        .addr_b (rd_ptr_q),
        .data_b ('0),
        .we_b   (1'b0),
        .q_b    (q_b)
    );

endmodule : dpram_stream_fifo

// File: tb/tb_dpram_stream_fifo.sv
// Directed bench for dpram_stream_fifo: driver tasks push expected words into
// exp_q on acceptance, an independent monitor pops and compares on every
// output handshake and checks head stability under backpressure.
module tb_dpram_stream_fifo;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW:0]   level;

    int total = 0;
    int bad = 0;
    int acc_cnt = 0;
    int pop_cnt = 0;

    logic [DW-1:0] exp_q[$];

    logic          held_v = 1'b0;
    logic [DW-1:0] held_d = '0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    dpram_stream_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // One clock cycle: drive at posedge+1, record acceptance at negedge,
    // return at the next posedge+1. Level is checked against the queue
    // occupancy every cycle.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r,
                         input logic c, output logic acc);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clr       = c;
        check("level", int'(level), exp_q.size());
        @(negedge clk);
        acc = 1'b0;
        if (c) begin
            exp_q.delete();
        end else if (v && in_ready) begin
            exp_q.push_back(d);
            acc_cnt++;
            acc = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        logic acc;
        int   n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            cycle(1'b0, '0, 1'b1, 1'b0, acc);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_drain_timeout: got %0d left want 0", name, exp_q.size());
            exp_q.delete();
        end
        check({name, "_empty_valid"}, int'(out_valid), 0);
        check({name, "_empty_level"}, int'(level), 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (held_v) check("stable", int'(out_data), int'(held_d));
                if (out_ready && !clr) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL pop_empty: got %0h want no word", out_data);
                    end else begin
                        check("data", int'(out_data), int'(exp_q.pop_front()));
                        pop_cnt++;
                    end
                end
                held_v = !out_ready && !clr;
                held_d = out_data;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic acc;
        int   a0;
        int   p0;
        int   w;
        int   n;

        // Reset held 3 cycles with in_valid asserted.
        in_valid = 1'b1;
        in_data  = 8'h99;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_in_ready", int'(in_ready), 0);
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_out_data", int'(out_data), 0);
            check("rst_level", int'(level), 0);
        end
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_pre", int'(in_ready), 0);
        cycle(1'b1, 8'h99, 1'b1, 1'b0, acc);
        check("rel_no_accept", int'(acc), 0);
        check("rel_in_ready_post", int'(in_ready), 1);

        // Single word: pushed at edge N, visible after edge N+2.
        p0 = pop_cnt;
        cycle(1'b1, 8'hAA, 1'b1, 1'b0, acc);
        check("sw_accept", int'(acc), 1);
        check("sw_valid_n", int'(out_valid), 0);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        check("sw_valid_n1", int'(out_valid), 0);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        check("sw_valid_n2", int'(out_valid), 1);
        check("sw_data", int'(out_data), 8'hAA);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        check("sw_popped", pop_cnt - p0, 1);
        check("sw_after_valid", int'(out_valid), 0);

        // Fill with consumer stalled: 64 RAM + 2 OB = 66 accepted.
        a0 = acc_cnt;
        for (int i = 0; i < 70; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, acc);
        check("fill_accepted", acc_cnt - a0, 66);
        check("fill_in_ready", int'(in_ready), 0);
        check("fill_level", int'(level), 66);
        p0 = pop_cnt;
        drain("fill");
        check("fill_popped", pop_cnt - p0, 66);

        // Full-rate stream with wrap: first pop happens at edge 3, after
        // which three words stay resident (RAM, read in flight, OB head).
        a0 = acc_cnt;
        p0 = pop_cnt;
        for (int c = 0; c < 200; c++) begin
            cycle(1'b1, 8'(c), 1'b1, 1'b0, acc);
            if (c >= 2) begin
                check("tp_level", int'(level), 3);
                check("tp_valid", int'(out_valid), 1);
            end
        end
        check("tp_accepted", acc_cnt - a0, 200);
        check("tp_popped", pop_cnt - p0, 197);
        drain("tp");

        // Backpressure: out_ready pattern 1,0,0,1; data held until accepted.
        w = 0;
        n = 0;
        while (w < 40 && n < 400) begin
            cycle(1'b1, 8'(8'h80 + w), ((n % 4) == 0) || ((n % 4) == 3), 1'b0, acc);
            if (acc) w++;
            n++;
        end
        check("bp_sent", w, 40);
        drain("bp");

        // Flush with level 10 and a read in flight.
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, acc);
        cycle(1'b1, 8'h1A, 1'b1, 1'b0, acc);
        check("clr_pre_level", int'(level), 10);
        cycle(1'b1, 8'h77, 1'b1, 1'b1, acc);
        check("clr_valid", int'(out_valid), 0);
        check("clr_level", int'(level), 0);
        check("clr_in_ready", int'(in_ready), 1);
        cycle(1'b1, 8'h5C, 1'b1, 1'b0, acc);
        check("clr_push_accept", int'(acc), 1);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        check("clr_first_valid", int'(out_valid), 1);
        check("clr_first_data", int'(out_data), 8'h5C);
        drain("clr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dpram_stream_fifo
